// File: rtl/axis_pkt_buffer.sv
// -----------------------------------------------------------------------------
// axis_pkt_buffer
//   Store-and-forward packet buffer. An AXI-Stream style packet is collected
//   into a DEPTH-entry buffer, then drained on the master side once complete.
//   A packet that reaches DEPTH beats without tlast is truncated: it is closed
//   as if the last beat carried tlast, and ovf pulses for one cycle.
//
//   Build option: define AXIS_PKT_BUFFER_REVERSE_EN to drain each packet in
//   reverse beat order. Length, m_last and handshakes are unchanged.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   s_axis_tdata   in   [DATA_WIDTH] input beat data
//   s_axis_tvalid  in   input beat valid
//   s_axis_tlast   in   final beat of an input packet
//   s_axis_tready  out  buffer can accept a beat (low while draining / in reset)
//   m_data         out  [DATA_WIDTH] output beat data (0 when not draining)
//   m_valid        out  output beat valid
//   m_last         out  final output beat
//   m_ready        in   consumer takes a beat
//   pkt_len        out  [CW] beat count of the most recently stored packet
//   ovf            out  one-cycle pulse when a packet was truncated at DEPTH
// -----------------------------------------------------------------------------
module axis_pkt_buffer #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [CW-1:0]         pkt_len,
    output logic                  ovf
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           wr_idx_q;
    logic [CW-1:0]           rd_idx_q;
    logic [CW-1:0]           pkt_len_q;
    logic                    m_valid_q;
    logic                    m_last_q;
    logic                    ovf_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    in_fire;
    logic                    out_fire;
    logic [CW-1:0]           wr_idx_d;
    logic [CW-1:0]           rd_idx_d;
    logic                    pkt_end;
    logic [AW-1:0]           rd_sel;

    // Ready depends on rst directly so it drops immediately on reset and is
    // already high in the first cycle after release.
    assign s_axis_tready = !rst && ((state_q == IDLE) || (state_q == FILL));

    always_comb begin
        in_fire  = s_axis_tvalid && s_axis_tready;
        out_fire = m_valid_q && m_ready;
        wr_idx_d = wr_idx_q + ONE;
        rd_idx_d = rd_idx_q + ONE;
        // Accepted beat closes the packet: explicit tlast or buffer full.
        pkt_end  = s_axis_tlast || (wr_idx_d == DEPTH_C);
`ifdef AXIS_PKT_BUFFER_REVERSE_EN
        rd_sel   = AW'(pkt_len_q - ONE - rd_idx_q);
`else
        rd_sel   = AW'(rd_idx_q);
`endif
    end

    assign m_data  = (state_q == DRAIN) ? mem_q[rd_sel] : '0;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign pkt_len = pkt_len_q;
    assign ovf     = ovf_q;

    // Storage is not reset; a discarded packet is simply overwritten.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_q[AW'(wr_idx_q)] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            pkt_len_q <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            case (state_q)
                IDLE, FILL: begin
                    if (in_fire) begin
                        wr_idx_q <= wr_idx_d;
                        if (pkt_end) begin
                            state_q   <= DRAIN;
                            pkt_len_q <= wr_idx_d;
                            rd_idx_q  <= '0;
                            m_valid_q <= 1'b1;
                            m_last_q  <= (wr_idx_d == ONE);
                            // pkt_end without tlast can only mean truncation.
                            ovf_q     <= !s_axis_tlast;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (m_last_q) begin
                            state_q   <= IDLE;
                            wr_idx_q  <= '0;
                            rd_idx_q  <= '0;
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                        end else begin
                            rd_idx_q <= rd_idx_d;
                            // m_last is registered, so look one index ahead.
                            m_last_q <= ((rd_idx_d + ONE) == pkt_len_q);
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    wr_idx_q  <= '0;
                    rd_idx_q  <= '0;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_buffer.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_buffer
//   Self-checking bench for axis_pkt_buffer (DATA_WIDTH=32, DEPTH=4).
//   Directed scenarios followed by randomized traffic, all compared against a
//   packet-level queue model. Define AXIS_PKT_BUFFER_REVERSE_EN for both the
//   RTL and the bench to check the reverse-order build.
// -----------------------------------------------------------------------------
module tb_axis_pkt_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic [CW-1:0] pkt_len;
    logic          ovf;

    always #5 clk = ~clk;

    axis_pkt_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .pkt_len       (pkt_len),
        .ovf           (ovf)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: beats of the packet being collected, and beats of the
    // completed packet still waiting to be delivered (in delivery order).
    logic [DW-1:0] cur_q [$];
    logic [DW-1:0] out_q [$];
    int unsigned   exp_len = 0;
    bit            exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                        input logic r, output bit acc);
        bit exp_vld;
        bit exp_rdy;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        m_ready       = r;
        #1;
        exp_vld = (out_q.size() != 0);
        exp_rdy = !exp_vld;
        chk("tready",  s_axis_tready, exp_rdy);
        chk("m_valid", m_valid, exp_vld);
        chk("m_last",  m_last, exp_vld && (out_q.size() == 1));
        chk("m_data",  m_data, exp_vld ? out_q[0] : '0);
        chk("pkt_len", pkt_len, exp_len);
        chk("ovf",     ovf, exp_ovf);
        acc     = v && exp_rdy;
        exp_ovf = 1'b0;
        if (exp_vld && r) void'(out_q.pop_front());
        if (acc) begin
            cur_q.push_back(d);
            if (l || cur_q.size() == DEPTH) begin
                exp_len = cur_q.size();
                exp_ovf = !l;
`ifdef AXIS_PKT_BUFFER_REVERSE_EN
                foreach (cur_q[i]) out_q.push_front(cur_q[i]);
`else
                foreach (cur_q[i]) out_q.push_back(cur_q[i]);
`endif
                cur_q.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 16) begin
            step(1'b1, d, l, 1'b1, acc);
            n++;
        end
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic idle(input int n, input logic r);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, r, acc);
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_tready",  s_axis_tready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last",  m_last, 1'b0);
        chk("rst_m_data",  m_data, '0);
        chk("rst_pkt_len", pkt_len, '0);
        chk("rst_ovf",     ovf, 1'b0);
        cur_q.delete();
        out_q.delete();
        exp_len = 0;
        exp_ovf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        @(negedge clk);
        do_reset();

        // Scenario 1: three-beat packet, consumer always ready.
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        send(32'h33, 1'b1);
        idle(4, 1'b1);

        // Scenario 2: five beats without tlast; truncation at DEPTH, E starts
        // the next packet once the drain completes.
        send(32'hA, 1'b0);
        send(32'hB, 1'b0);
        send(32'hC, 1'b0);
        send(32'hD, 1'b0);
        send(32'hE, 1'b0);
        send(32'hF, 1'b1);
        idle(4, 1'b1);

        // Scenario 3: single-beat packet.
        send(32'hDEAD, 1'b1);
        idle(3, 1'b1);

        // Scenario 4: stalled drain with input beats offered meanwhile.
        send(32'h101, 1'b0);
        send(32'h202, 1'b0);
        send(32'h303, 1'b1);
        step(1'b1, 32'h999, 1'b0, 1'b1, acc);
        step(1'b1, 32'h999, 1'b0, 1'b0, acc);
        step(1'b1, 32'h999, 1'b0, 1'b0, acc);
        step(1'b1, 32'h999, 1'b0, 1'b1, acc);
        idle(3, 1'b1);

        // Scenario 5: reset mid-fill discards the partial packet.
        send(32'h77, 1'b0);
        send(32'h88, 1'b0);
        do_reset();
        send(32'h55, 1'b1);
        idle(3, 1'b1);

        // Scenario 6: tvalid low with toggling/unknown data.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i % 2 == 0) ? 32'h0 : 32'hx, 1'b0, 1'($urandom_range(0, 1)), acc);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0), $urandom,
                     1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 2) != 0), acc);
            end
        end
        send(32'hC0DE, 1'b1);
        idle(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
